// File: rtl/legv8_mem_arbiter_pkg.sv
// legv8_pkg: shared widths and the arbiter state encoding.
//   ADDR_W  byte-address width of fetch, data and memory ports
//   DATA_W  memory / data-port word width
//   INSN_W  instruction word width returned to the fetch port
//   arb_state_t  IDLE -> WAIT -> RESP -> IDLE
package legv8_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INSN_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/legv8_mem_arbiter_if.sv
// legv8_mem_arbiter_if: bundle of the fetch port, data port, memory port
// and bus error flag seen by the arbiter.
//   master : arbiter view (receives requests and mem_ack/mem_rdata, drives
//            acks, read data, memory request and bus_err)
//   slave  : environment view (CPU requesters plus memory model)
interface legv8_mem_arbiter_if;
  import legv8_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [INSN_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, bus_err
  );
endinterface

// File: rtl/legv8_mem_arbiter_timeout_counter.sv
// legv8_timeout_counter: counts cycles spent waiting for memory.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : zero the count (asserted on the edge that enters WAIT)
//   enable       : count this cycle (high while in WAIT)
//   expired      : this is the LIMIT-th enabled cycle since the clear
module legv8_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(LIMIT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The count holds the number of completed enabled cycles, so the cycle whose
  // closing edge would make it reach LIMIT is the last one allowed.
  assign expired = enable && (count_reg == CW'(LIMIT - 1));
endmodule

// File: rtl/legv8_mem_arbiter.sv
// legv8_mem_arbiter: shares one memory port between instruction fetch and
// data accesses, one transaction outstanding at a time.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : legv8_mem_arbiter_if.master (fetch, data, memory ports)
// Data wins over fetch unless fetch has been passed over STARVE_MAX times in
// a row. A memory access not acked within TIMEOUT cycles completes with zero
// data and a bus_err pulse alongside the requester's ack.
module legv8_mem_arbiter
  import legv8_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  legv8_mem_arbiter_if.master   bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state_reg, state_next;
  logic              fetch_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [SW-1:0]     starve_reg;

  logic grant;
  logic grant_fetch;
  logic timeout;

  legv8_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (grant),
    .enable  (state_reg == WAIT),
    .expired (timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    grant_fetch = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant       = 1'b1;
          grant_fetch = bus.if_req &&
                        (!bus.d_req || (starve_reg == SW'(STARVE_MAX)));
          state_next  = WAIT;
        end
      end
      WAIT: begin
        // An ack in the final allowed cycle still completes normally.
        if (bus.mem_ack || timeout) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      starve_reg <= '0;
    end else begin
      if (grant) begin
        fetch_reg <= grant_fetch;
        we_reg    <= !grant_fetch && bus.d_we;
        addr_reg  <= grant_fetch ? bus.if_addr : bus.d_addr;
        wdata_reg <= grant_fetch ? '0 : bus.d_wdata;
        err_reg   <= 1'b0;
        // Only a data grant that bypasses a waiting fetch extends the streak.
        if (grant_fetch || !bus.if_req) begin
          starve_reg <= '0;
        end else if (starve_reg != SW'(STARVE_MAX)) begin
          starve_reg <= starve_reg + 1'b1;
        end
      end
      if (state_reg == WAIT) begin
        if (bus.mem_ack) begin
          rdata_reg <= bus.mem_rdata;
        end else if (timeout) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end
      end
    end
  end

  // Memory-side outputs derive from the state so reset removes them at once.
  assign bus.mem_req   = (state_reg == WAIT);
  assign bus.mem_we    = bus.mem_req && we_reg;
  assign bus.mem_addr  = addr_reg & ~ADDR_W'(7);
  assign bus.mem_wdata = wdata_reg;

  assign bus.if_ack    = (state_reg == RESP) && fetch_reg;
  assign bus.d_ack     = (state_reg == RESP) && !fetch_reg;
  assign bus.bus_err   = (state_reg == RESP) && err_reg;

  // Address bit 2 picks which instruction of the fetched doubleword is wanted.
  assign bus.if_rdata  = addr_reg[2] ? rdata_reg[DATA_W-1:INSN_W]
                                     : rdata_reg[INSN_W-1:0];
  assign bus.d_rdata   = rdata_reg;
endmodule

// File: tb/tb_legv8_mem_arbiter.sv
`timescale 1ns/1ps
module tb_legv8_mem_arbiter;
  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  legv8_mem_arbiter_if bus_if ();

  legv8_mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Requester state (what the TB CPU is currently asking for)
  bit          i_pend, d_pend, d_we_m;
  logic [63:0] i_addr_m, d_addr_m, d_wdata_m;
  bit          rand_mode;
  int          i_left, d_left;
  logic [63:0] i_dir_addr, d_dir_addr, d_dir_wdata;
  bit          d_dir_we;
  int          lat_force;
  bit          data_force_en;
  logic [63:0] data_force;

  // Transaction-level reference: each accepted request occupies the memory
  // port from cycle 'issue' for 'len' cycles and is acked in cycle issue+len.
  int          t;
  bit          busy;
  int          issue, lat, len, next_idle, starve;
  bit          win_fetch, x_we;
  logic [63:0] x_addr, x_wdata, x_word;
  int          ack_cnt;
  string       order;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic drive_inputs(input bit ack, input logic [63:0] rdata);
    bus_if.if_req    = i_pend;
    bus_if.if_addr   = i_addr_m;
    bus_if.d_req     = d_pend;
    bus_if.d_we      = d_we_m;
    bus_if.d_addr    = d_addr_m;
    bus_if.d_wdata   = d_wdata_m;
    bus_if.mem_ack   = ack;
    bus_if.mem_rdata = rdata;
  endtask

  task automatic step();
    bit          in_wait, at_ack, ack;
    logic [63:0] exp_word, rdata;
    @(negedge clock);
    t++;
    in_wait = busy && (t >= issue) && (t < issue + len);
    at_ack  = busy && (t == issue + len);
    chk("mem_req", bus_if.mem_req, in_wait);
    if (in_wait) begin
      chk("mem_we", bus_if.mem_we, x_we);
      chk("mem_addr", bus_if.mem_addr, x_addr & ~64'd7);
      if (x_we) chk("mem_wdata", bus_if.mem_wdata, x_wdata);
    end
    chk("if_ack", bus_if.if_ack, at_ack && win_fetch);
    chk("d_ack", bus_if.d_ack, at_ack && !win_fetch);
    chk("bus_err", bus_if.bus_err, at_ack && (lat >= TIMEOUT));
    if (bus_if.if_ack === 1'b1) begin order = {order, "I"}; ack_cnt++; end
    if (bus_if.d_ack === 1'b1) begin order = {order, "D"}; ack_cnt++; end
    if (at_ack) begin
      exp_word = (lat >= TIMEOUT) ? 64'd0 : x_word;
      if (win_fetch) begin
        chk("if_rdata", bus_if.if_rdata, x_addr[2] ? exp_word[63:32] : exp_word[31:0]);
        i_pend = 1'b0;
      end else begin
        if (!x_we) chk("d_rdata", bus_if.d_rdata, exp_word);
        d_pend = 1'b0;
      end
      $display("txn %0d: %s addr=%h we=%0d lat=%0d err=%0d", ack_cnt,
               win_fetch ? "fetch" : "data", x_addr, x_we, lat, lat >= TIMEOUT);
      busy      = 1'b0;
      next_idle = t + 1;
    end

    // New requests for this cycle
    if (!i_pend && (rand_mode ? ($urandom_range(2) == 0) : (i_left > 0))) begin
      i_pend   = 1'b1;
      i_addr_m = rand_mode ? {$urandom, $urandom} : i_dir_addr;
      if (!rand_mode) i_left--;
    end
    if (!d_pend && (rand_mode ? ($urandom_range(2) == 0) : (d_left > 0))) begin
      d_pend    = 1'b1;
      d_we_m    = rand_mode ? 1'($urandom_range(1)) : d_dir_we;
      d_addr_m  = rand_mode ? {$urandom, $urandom} : d_dir_addr;
      d_wdata_m = rand_mode ? {$urandom, $urandom} : d_dir_wdata;
      if (!rand_mode) d_left--;
    end

    // Arbitration decision for requests seen at the end of an idle cycle
    if (!busy && (t >= next_idle) && (i_pend || d_pend)) begin
      win_fetch = i_pend && (!d_pend || (starve == STARVE_MAX));
      if (!win_fetch && i_pend) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      else starve = 0;
      x_addr  = win_fetch ? i_addr_m : d_addr_m;
      x_we    = !win_fetch && d_we_m;
      x_wdata = d_wdata_m;
      issue   = t + 1;
      if (lat_force >= 0) lat = lat_force;
      else begin
        case ($urandom_range(9))
          6:       lat = 15;
          7:       lat = 16;
          8:       lat = 20;
          9:       lat = 1;
          default: lat = int'($urandom_range(5));
        endcase
      end
      len    = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
      x_word = data_force_en ? data_force : {$urandom, $urandom};
      busy   = 1'b1;
    end

    // Memory responder; stray acks outside the wait window must be ignored
    ack   = busy && (t == issue + lat) && (lat < TIMEOUT);
    rdata = ack ? x_word : {$urandom, $urandom};
    if (!ack && rand_mode && !(busy && (t >= issue) && (t < issue + len)) &&
        ($urandom_range(7) == 0)) ack = 1'b1;
    drive_inputs(ack, rdata);
  endtask

  task automatic run_acks(input int n, input int budget);
    int start;
    int k;
    start = ack_cnt;
    k = 0;
    while ((ack_cnt - start < n) && (k < budget)) begin
      step();
      k++;
    end
    chk("ack_count", 64'(ack_cnt - start), 64'(n));
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    i_pend = 0; d_pend = 0; d_we_m = 0;
    i_addr_m = '0; d_addr_m = '0; d_wdata_m = '0;
    rand_mode = 0; i_left = 0; d_left = 0;
    i_dir_addr = '0; d_dir_addr = '0; d_dir_wdata = '0; d_dir_we = 0;
    lat_force = -1; data_force_en = 0; data_force = '0;
    t = 0; busy = 0; issue = 0; lat = 0; len = 0; next_idle = 0; starve = 0;
    win_fetch = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_word = '0;
    ack_cnt = 0; order = "";
    drive_inputs(1'b0, 64'd0);

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_req", bus_if.mem_req, 1'b0);
    chk("rst_mem_we", bus_if.mem_we, 1'b0);
    chk("rst_if_ack", bus_if.if_ack, 1'b0);
    chk("rst_d_ack", bus_if.d_ack, 1'b0);
    chk("rst_bus_err", bus_if.bus_err, 1'b0);
    chk("rst_mem_addr", bus_if.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus_if.mem_wdata, 64'd0);
    chk("rst_d_rdata", bus_if.d_rdata, 64'd0);
    reset = 1'b0;
    idle_steps(2);

    // Single load, memory acks two cycles after mem_req rises
    data_force_en = 1; data_force = 64'hAABB;
    lat_force = 2; d_dir_we = 0; d_dir_addr = 64'h10; d_dir_wdata = 64'h0;
    d_left = 1;
    run_acks(1, 20);
    idle_steps(2);

    // Single fetch of the upper instruction of a doubleword
    data_force = 64'h11112222_33334444; lat_force = 1;
    i_dir_addr = 64'h104; i_left = 1;
    run_acks(1, 20);
    idle_steps(2);

    // Both requesters continuously busy, immediate memory ack
    data_force_en = 0; lat_force = 0;
    i_dir_addr = 64'h200; d_dir_addr = 64'h3008; d_dir_we = 0;
    order = "";
    i_left = 2; d_left = 8;
    run_acks(10, 80);
    checks++;
    assert (order == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order: observed %s expected DDDDIDDDDI", order);
    end
    idle_steps(2);

    // Store that memory never acks: timeout with bus_err
    lat_force = 100; d_dir_we = 1; d_dir_addr = 64'h48; d_dir_wdata = 64'hDEAD_BEEF_0123_4567;
    d_left = 1;
    run_acks(1, 40);
    idle_steps(2);

    // Reset while waiting on memory
    d_dir_we = 1; d_dir_addr = 64'h80; d_left = 1;
    for (int k = 0; k < 20 && !(busy && t == issue + 3); k++) step();
    chk("rst_reached_wait", bus_if.mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_req", bus_if.mem_req, 1'b0);
    chk("midrst_mem_we", bus_if.mem_we, 1'b0);
    chk("midrst_d_ack", bus_if.d_ack, 1'b0);
    chk("midrst_bus_err", bus_if.bus_err, 1'b0);
    busy = 0; i_pend = 0; d_pend = 0; i_left = 0; d_left = 0; starve = 0;
    drive_inputs(1'b0, 64'd0);
    @(negedge clock);
    t++;
    chk("inrst_d_ack", bus_if.d_ack, 1'b0);
    reset = 1'b0;
    next_idle = t;
    idle_steps(20);
    lat_force = 1; data_force_en = 1; data_force = 64'h0BAD_F00D_CAFE_0001;
    d_dir_we = 0; d_dir_addr = 64'h98; d_left = 1;
    run_acks(1, 20);
    idle_steps(2);

    // Randomized traffic against the reference timeline
    data_force_en = 0; lat_force = -1; rand_mode = 1;
    idle_steps(600);
    rand_mode = 0;
    for (int k = 0; k < 100 && (busy || i_pend || d_pend); k++) step();
    chk("drained", 64'(busy || i_pend || d_pend), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
